// File: rtl/rvm_fu_arbiter_pkg.sv
// Shared unit codes, FSM states and request bundle for the FU arbiter.
// Default watchdog limit lives here too.
package rvm_fu_arbiter_pkg;

  localparam logic [1:0] RVM_FU_ADD = 2'b00;
  localparam logic [1:0] RVM_FU_BIT = 2'b01;
  localparam logic [1:0] RVM_FU_SHF = 2'b10;
  localparam logic [1:0] RVM_FU_ILL = 2'b11;

  localparam int unsigned RVM_ARB_TIMEOUT = 64;

  typedef enum logic [1:0] {
    RVM_ARB_IDLE = 2'b00,
    RVM_ARB_BUSY = 2'b01,
    RVM_ARB_DONE = 2'b10
  } arb_state_e;

  typedef struct packed {
    logic [1:0]  unit;
    logic [1:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
  } fu_req_t;

  function automatic logic [2:0] fu_sel(logic [1:0] unit);
    logic [2:0] s;
    s = '0;
    case (unit)
      RVM_FU_ADD: s = 3'b001;
      RVM_FU_BIT: s = 3'b010;
      RVM_FU_SHF: s = 3'b100;
      default:    s = 3'b000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rvm_fu_arb_pick.sv
// Winner selection between ports A and B.
// RVM_FU_ARB_RR_EN selects round-robin, otherwise A has fixed priority.
module rvm_fu_arb_pick (
`ifdef RVM_FU_ARB_RR_EN
  input  logic ptr_i,
`endif
  input  logic a_vld_i,
  input  logic b_vld_i,
  output logic grant_o,
  output logic pick_b_o
);

  assign grant_o = a_vld_i | b_vld_i;

`ifdef RVM_FU_ARB_RR_EN
  // ptr_i high means B has priority on a tie
  assign pick_b_o = b_vld_i & (~a_vld_i | ptr_i);
`else
  assign pick_b_o = b_vld_i & ~a_vld_i;
`endif

endmodule

// File: rtl/rvm_fu_arbiter.sv
// Shares add/bit/shf units between execute (A) and PC (B) requesters.
// Define RVM_FU_ARB_RR_EN for round-robin arbitration.
module rvm_fu_arbiter
  import rvm_fu_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = RVM_ARB_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req_valid,
  input  logic [1:0]  a_req_unit,
  input  logic [1:0]  a_req_op,
  input  logic [31:0] a_req_lhs,
  input  logic [31:0] a_req_rhs,
  output logic        a_rsp_valid,
  output logic [32:0] a_rsp_result,
  output logic        a_rsp_err,
  input  logic        b_req_valid,
  input  logic [1:0]  b_req_unit,
  input  logic [1:0]  b_req_op,
  input  logic [31:0] b_req_lhs,
  input  logic [31:0] b_req_rhs,
  output logic        b_rsp_valid,
  output logic [32:0] b_rsp_result,
  output logic        b_rsp_err,
  output logic [31:0] f_add_lhs,
  output logic [31:0] f_add_rhs,
  output logic [1:0]  f_add_op,
  input  logic        f_add_valid,
  input  logic [32:0] f_add_result,
  output logic [31:0] f_bit_lhs,
  output logic [31:0] f_bit_rhs,
  output logic [1:0]  f_bit_op,
  input  logic        f_bit_valid,
  input  logic [31:0] f_bit_result,
  output logic [31:0] f_shf_lhs,
  output logic [31:0] f_shf_rhs,
  output logic [1:0]  f_shf_op,
  input  logic        f_shf_valid,
  input  logic [31:0] f_shf_result,
  output logic        busy
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  arb_state_e  state_q;
  logic [2:0]  sel_q;
  logic [1:0]  op_q;
  logic [31:0] lhs_q;
  logic [31:0] rhs_q;
  logic        win_b_q;
  logic [7:0]  wd_q;
  logic        busy_q;
  logic        a_vld_q, b_vld_q;
  logic        a_err_q, b_err_q;
  logic [32:0] a_res_q, b_res_q;

  logic        grant, pick_b;
  fu_req_t     a_req, b_req, win_req;
  logic        fu_vld;
  logic [32:0] fu_res;
  logic        fin_d, fin_b_d, fin_err_d;
  logic [32:0] fin_res_d;

`ifdef RVM_FU_ARB_RR_EN
  logic ptr_q;
`endif

  rvm_fu_arb_pick u_pick (
`ifdef RVM_FU_ARB_RR_EN
    .ptr_i    (ptr_q),
`endif
    .a_vld_i  (a_req_valid),
    .b_vld_i  (b_req_valid),
    .grant_o  (grant),
    .pick_b_o (pick_b)
  );

  assign a_req   = '{a_req_unit, a_req_op, a_req_lhs, a_req_rhs};
  assign b_req   = '{b_req_unit, b_req_op, b_req_lhs, b_req_rhs};
  assign win_req = pick_b ? b_req : a_req;

  always_comb begin
    fu_vld = 1'b0;
    fu_res = '0;
    unique case (1'b1)
      sel_q[0]: begin
        fu_vld = f_add_valid;
        fu_res = f_add_result;
      end
      sel_q[1]: begin
        fu_vld = f_bit_valid;
        fu_res = {1'b0, f_bit_result};
      end
      sel_q[2]: begin
        fu_vld = f_shf_valid;
        fu_res = {1'b0, f_shf_result};
      end
      default: ;
    endcase
  end

  // wd_q == 0 marks the operand-settle cycle, so valid is ignored there
  always_comb begin
    fin_d     = 1'b0;
    fin_b_d   = win_b_q;
    fin_err_d = 1'b0;
    fin_res_d = '0;
    if (state_q == RVM_ARB_IDLE) begin
      if (grant && win_req.unit == RVM_FU_ILL) begin
        fin_d     = 1'b1;
        fin_b_d   = pick_b;
        fin_err_d = 1'b1;
      end
    end else if (state_q == RVM_ARB_BUSY) begin
      if (wd_q != '0 && fu_vld) begin
        fin_d     = 1'b1;
        fin_res_d = fu_res;
      end else if (wd_q == TMO) begin
        fin_d     = 1'b1;
        fin_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RVM_ARB_IDLE;
      sel_q   <= '0;
      op_q    <= '0;
      lhs_q   <= '0;
      rhs_q   <= '0;
      win_b_q <= 1'b0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      a_err_q <= 1'b0;
      b_err_q <= 1'b0;
      a_res_q <= '0;
      b_res_q <= '0;
`ifdef RVM_FU_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      unique case (state_q)
        RVM_ARB_IDLE: begin
          if (grant) begin
            op_q    <= win_req.op;
            lhs_q   <= win_req.lhs;
            rhs_q   <= win_req.rhs;
            win_b_q <= pick_b;
            wd_q    <= '0;
            busy_q  <= 1'b1;
`ifdef RVM_FU_ARB_RR_EN
            ptr_q   <= ~pick_b;
`endif
            if (win_req.unit == RVM_FU_ILL) begin
              state_q <= RVM_ARB_DONE;
            end else begin
              sel_q   <= fu_sel(win_req.unit);
              state_q <= RVM_ARB_BUSY;
            end
          end
        end
        RVM_ARB_BUSY: begin
          wd_q <= wd_q + 8'd1;
          if (fin_d) begin
            sel_q   <= '0;
            state_q <= RVM_ARB_DONE;
          end
        end
        RVM_ARB_DONE: begin
          busy_q  <= 1'b0;
          state_q <= RVM_ARB_IDLE;
        end
        default: state_q <= RVM_ARB_IDLE;
      endcase
      if (fin_d) begin
        if (fin_b_d) begin
          b_vld_q <= 1'b1;
          b_res_q <= fin_res_d;
          b_err_q <= fin_err_d;
        end else begin
          a_vld_q <= 1'b1;
          a_res_q <= fin_res_d;
          a_err_q <= fin_err_d;
        end
      end
    end
  end

  assign f_add_lhs = sel_q[0] ? lhs_q : '0;
  assign f_add_rhs = sel_q[0] ? rhs_q : '0;
  assign f_add_op  = sel_q[0] ? op_q  : '0;
  assign f_bit_lhs = sel_q[1] ? lhs_q : '0;
  assign f_bit_rhs = sel_q[1] ? rhs_q : '0;
  assign f_bit_op  = sel_q[1] ? op_q  : '0;
  assign f_shf_lhs = sel_q[2] ? lhs_q : '0;
  assign f_shf_rhs = sel_q[2] ? rhs_q : '0;
  assign f_shf_op  = sel_q[2] ? op_q  : '0;

  assign a_rsp_valid  = a_vld_q;
  assign a_rsp_result = a_res_q;
  assign a_rsp_err    = a_err_q;
  assign b_rsp_valid  = b_vld_q;
  assign b_rsp_result = b_res_q;
  assign b_rsp_err    = b_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rvm_fu_arbiter.sv
// Scoreboard bench for rvm_fu_arbiter with TIMEOUT=8.
// Behavioural functional units respond from the DUT's f_* operands.
module tb_rvm_fu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req_valid, b_req_valid;
  logic [1:0]  a_req_unit, a_req_op, b_req_unit, b_req_op;
  logic [31:0] a_req_lhs, a_req_rhs, b_req_lhs, b_req_rhs;
  logic        a_rsp_valid, a_rsp_err, b_rsp_valid, b_rsp_err;
  logic [32:0] a_rsp_result, b_rsp_result;
  logic [31:0] f_add_lhs, f_add_rhs, f_bit_lhs, f_bit_rhs;
  logic [31:0] f_shf_lhs, f_shf_rhs;
  logic [1:0]  f_add_op, f_bit_op, f_shf_op;
  logic        f_add_valid, f_bit_valid, f_shf_valid;
  logic [32:0] f_add_result;
  logic [31:0] f_bit_result, f_shf_result;
  logic        busy;

  always #5 clk = ~clk;

  rvm_fu_arbiter #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_req_valid  (a_req_valid),
    .a_req_unit   (a_req_unit),
    .a_req_op     (a_req_op),
    .a_req_lhs    (a_req_lhs),
    .a_req_rhs    (a_req_rhs),
    .a_rsp_valid  (a_rsp_valid),
    .a_rsp_result (a_rsp_result),
    .a_rsp_err    (a_rsp_err),
    .b_req_valid  (b_req_valid),
    .b_req_unit   (b_req_unit),
    .b_req_op     (b_req_op),
    .b_req_lhs    (b_req_lhs),
    .b_req_rhs    (b_req_rhs),
    .b_rsp_valid  (b_rsp_valid),
    .b_rsp_result (b_rsp_result),
    .b_rsp_err    (b_rsp_err),
    .f_add_lhs    (f_add_lhs),
    .f_add_rhs    (f_add_rhs),
    .f_add_op     (f_add_op),
    .f_add_valid  (f_add_valid),
    .f_add_result (f_add_result),
    .f_bit_lhs    (f_bit_lhs),
    .f_bit_rhs    (f_bit_rhs),
    .f_bit_op     (f_bit_op),
    .f_bit_valid  (f_bit_valid),
    .f_bit_result (f_bit_result),
    .f_shf_lhs    (f_shf_lhs),
    .f_shf_rhs    (f_shf_rhs),
    .f_shf_op     (f_shf_op),
    .f_shf_valid  (f_shf_valid),
    .f_shf_result (f_shf_result),
    .busy         (busy)
  );

  function automatic logic [31:0] bitop(
    logic [1:0] op, logic [31:0] l, logic [31:0] r);
    case (op)
      2'd0:    return l & r;
      2'd1:    return l | r;
      2'd2:    return l ^ r;
      default: return ~(l & r);
    endcase
  endfunction

  function automatic logic [31:0] shfop(
    logic [1:0] op, logic [31:0] l, logic [31:0] r);
    return op[0] ? (l >> r[4:0]) : (l << r[4:0]);
  endfunction

  assign f_add_result = {1'b0, f_add_lhs} + {1'b0, f_add_rhs};
  assign f_bit_result = bitop(f_bit_op, f_bit_lhs, f_bit_rhs);
  assign f_shf_result = shfop(f_shf_op, f_shf_lhs, f_shf_rhs);

  function automatic logic [32:0] ref_res(
    logic [1:0] u, logic [1:0] op, logic [31:0] l, logic [31:0] r);
    case (u)
      2'd0:    return {1'b0, l} + {1'b0, r};
      2'd1:    return {1'b0, bitop(op, l, r)};
      2'd2:    return {1'b0, shfop(op, l, r)};
      default: return 33'd0;
    endcase
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [32:0] res;
    logic        err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   a_cyc = 0, b_cyc = 0;
  bit   last_b = 1'b1;
  bit   watch_f = 1'b0;
  bit   f_seen = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : mon
    exp_t e;
    if (a_rsp_valid) begin
      a_cyc  = cyc;
      last_b = 1'b0;
      if (qa.size() == 0) chk("a_unexp", 64'd1, 64'd0);
      else begin
        e = qa.pop_front();
        chk("a_res", 64'(a_rsp_result), 64'(e.res));
        chk("a_err", 64'(a_rsp_err), 64'(e.err));
      end
    end
    if (b_rsp_valid) begin
      b_cyc  = cyc;
      last_b = 1'b1;
      if (qb.size() == 0) chk("b_unexp", 64'd1, 64'd0);
      else begin
        e = qb.pop_front();
        chk("b_res", 64'(b_rsp_result), 64'(e.res));
        chk("b_err", 64'(b_rsp_err), 64'(e.err));
      end
    end
    if (watch_f && (|{f_add_lhs, f_add_rhs, f_add_op, f_bit_lhs,
                      f_bit_rhs, f_bit_op, f_shf_lhs, f_shf_rhs,
                      f_shf_op}))
      f_seen = 1'b1;
  end

  task automatic req(input bit p, input logic [1:0] u,
                     input logic [1:0] op, input logic [31:0] l,
                     input logic [31:0] r, input logic eerr,
                     output int lat);
    exp_t e;
    e.res = eerr ? 33'd0 : ref_res(u, op, l, r);
    e.err = eerr;
    if (p) begin
      qb.push_back(e);
      b_req_unit = u; b_req_op = op;
      b_req_lhs = l; b_req_rhs = r;
      b_req_valid = 1'b1;
    end else begin
      qa.push_back(e);
      a_req_unit = u; a_req_op = op;
      a_req_lhs = l; a_req_rhs = r;
      a_req_valid = 1'b1;
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (p ? b_rsp_valid : a_rsp_valid) begin
        lat = k - 1;
        break;
      end
    end
    if (lat < 0) chk(p ? "b_no_rsp" : "a_no_rsp", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    if (p) b_req_valid = 1'b0;
    else a_req_valid = 1'b0;
  endtask

  initial begin : main
    int lat, la, la2, lb, exp_bl;
    bit a_first;
    reset = 1'b1;
    a_req_valid = 0; a_req_unit = 0; a_req_op = 0;
    a_req_lhs = 0; a_req_rhs = 0;
    b_req_valid = 0; b_req_unit = 0; b_req_op = 0;
    b_req_lhs = 0; b_req_rhs = 0;
    f_add_valid = 1; f_bit_valid = 1; f_shf_valid = 1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp", 64'({a_rsp_valid, a_rsp_err, b_rsp_valid, b_rsp_err}), 64'd0);
    chk("rst_res", 64'(a_rsp_result | b_rsp_result), 64'd0);
    chk("rst_f", 64'(|{f_add_lhs, f_add_rhs, f_add_op, f_bit_lhs, f_bit_rhs,
                       f_bit_op, f_shf_lhs, f_shf_rhs, f_shf_op}), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // single add with carry, adder valid stuck high
    req(1'b0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, lat);
    chk("add_lat", 64'(lat), 64'd3);
    chk("a_hold", 64'(a_rsp_result), 64'h1_0000_0000);

    for (int i = 0; i < 6; i++) begin
      req(bit'(i % 2), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
          $urandom, $urandom, 1'b0, lat);
      chk("rnd_lat", 64'(lat), 64'd3);
    end

    // illegal unit on B
    f_seen = 1'b0;
    watch_f = 1'b1;
    req(1'b1, 2'd3, 2'd1, 32'h1234, 32'h5678, 1'b1, lat);
    watch_f = 1'b0;
    chk("ill_f_zero", 64'(f_seen), 64'd0);

    // timeout with bit unit silent
    f_bit_valid = 1'b0;
    req(1'b0, 2'd1, 2'd0, 32'hF0F0, 32'hFF00, 1'b1, lat);
    chk("tmo_lat", 64'(lat), 64'd10);

    // valid in the expiry cycle wins
    fork
      req(1'b0, 2'd1, 2'd2, 32'hA5A5_0000, 32'h0F0F_FFFF, 1'b0, lat);
      begin
        repeat (9) @(posedge clk);
        #1 f_bit_valid = 1'b1;
        @(posedge clk);
        #1 f_bit_valid = 1'b0;
      end
    join
    chk("exp_lat", 64'(lat), 64'd10);
    f_bit_valid = 1'b1;

    // plain tie
`ifdef RVM_FU_ARB_RR_EN
    a_first = last_b;
`else
    a_first = 1'b1;
`endif
    fork
      req(1'b0, 2'd2, 2'd0, 32'h0000_00F1, 32'd4, 1'b0, la);
      req(1'b1, 2'd1, 2'd1, 32'h00FF_0000, 32'h0000_0F0F, 1'b0, lb);
    join
    chk("tie1_order", 64'(a_cyc < b_cyc), 64'(a_first));
    chk("tie1_lat", 64'(a_first ? lb : la), 64'd7);

    // tie where A re-requests right after its response
`ifdef RVM_FU_ARB_RR_EN
    exp_bl = last_b ? 7 : 3;
`else
    exp_bl = 11;
`endif
    fork
      begin
        req(1'b0, 2'd2, 2'd1, 32'h8000_0000, 32'd31, 1'b0, la);
        req(1'b0, 2'd0, 2'd3, 32'h7FFF_FFFF, 32'd2, 1'b0, la2);
      end
      req(1'b1, 2'd1, 2'd2, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b0, lb);
    join
    chk("tie2_b_lat", 64'(lb), 64'(exp_bl));

    // reset during BUSY drops the request silently
    f_add_valid = 1'b0;
    a_req_unit = 2'd0; a_req_op = 2'd0;
    a_req_lhs = 32'd5; a_req_rhs = 32'd6;
    a_req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_f", 64'(|{f_add_lhs, f_add_rhs, f_add_op}), 64'd0);
    chk("mid_rst_rsp", 64'({a_rsp_valid, a_rsp_err, a_rsp_result}), 64'd0);
    a_req_valid = 1'b0;
    last_b = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    f_add_valid = 1'b1;
    @(posedge clk);
    #1;
    req(1'b0, 2'd0, 2'd0, 32'd5, 32'd6, 1'b0, lat);
    chk("rereq_lat", 64'(lat), 64'd3);

    repeat (3) @(posedge clk);
    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
